// File: rtl/yutorina_timer_pkg.sv
// Shared definitions for the yutorina bus timer: register map, bit positions,
// bus widths and the bus-level encodings the timer relies on.
package yutorina_timer_pkg;

  localparam int WORD_DATA_W   = 32;
  localparam int TIMER_ADDR_W  = 2;

  localparam logic READ        = 1'b1;
  localparam logic WRITE       = 1'b0;
  localparam logic ENABLE_     = 1'b0;
  localparam logic DISABLE_    = 1'b1;

  typedef enum logic [TIMER_ADDR_W-1:0] {
    REG_CTRL    = 2'd0,
    REG_INTR    = 2'd1,
    REG_EXPR    = 2'd2,
    REG_COUNTER = 2'd3
  } timer_reg_e;

  localparam int START_BIT     = 0;
  localparam int PERIODIC_BIT  = 1;
  localparam int FLAG_BIT      = 0;

  // CTRL readback: only start and periodic are implemented, the rest read 0.
  function automatic logic [WORD_DATA_W-1:0] pack_ctrl(input logic start,
                                                       input logic periodic);
    logic [WORD_DATA_W-1:0] value;
    value = '0;
    value[START_BIT]    = start;
    value[PERIODIC_BIT] = periodic;
    return value;
  endfunction

endpackage

// File: rtl/yutorina_timer.sv
// Memory-mapped 32-bit timer with one-shot/periodic expiry, interrupt flag and
// a single-cycle registered bus response.
module yutorina_timer
  import yutorina_timer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_,
  input  logic                    as_,
  input  logic                    rw,
  input  logic [TIMER_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0]  w_data,
  output logic [WORD_DATA_W-1:0]  r_data,
  output logic                    rdy_,
  output logic                    irq
);

  logic                   start;
  logic                   periodic;
  logic                   flag;
  logic [WORD_DATA_W-1:0] expr;
  logic [WORD_DATA_W-1:0] counter;

  logic                   access;
  logic                   wr_ctrl;
  logic                   wr_intr;
  logic                   wr_expr;
  logic                   wr_counter;
  logic                   expire;
  logic [WORD_DATA_W-1:0] read_value;

  assign access     = (cs_ == ENABLE_) && (as_ == ENABLE_);
  assign wr_ctrl    = access && (rw == WRITE) && (addr == REG_CTRL);
  assign wr_intr    = access && (rw == WRITE) && (addr == REG_INTR);
  assign wr_expr    = access && (rw == WRITE) && (addr == REG_EXPR);
  assign wr_counter = access && (rw == WRITE) && (addr == REG_COUNTER);

  // A bus write to COUNTER suppresses that cycle's expiry entirely.
  assign expire = start && (counter == expr) && !wr_counter;

  assign irq = flag;

  always_comb begin
    read_value = '0;
    case (addr)
      REG_CTRL:    read_value = pack_ctrl(start, periodic);
      REG_INTR:    read_value[FLAG_BIT] = flag;
      REG_EXPR:    read_value = expr;
      REG_COUNTER: read_value = counter;
      default:     read_value = '0;
    endcase
  end

  // Registered bus response: one rdy_ pulse per accepted access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_   <= DISABLE_;
      r_data <= '0;
    end else if (access) begin
      rdy_   <= ENABLE_;
      r_data <= (rw == READ) ? read_value : '0;
    end else begin
      rdy_   <= DISABLE_;
      r_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start    <= 1'b0;
      periodic <= 1'b0;
    end else if (wr_ctrl) begin
      start    <= w_data[START_BIT];
      periodic <= w_data[PERIODIC_BIT];
    end else if (expire && !periodic) begin
      start    <= 1'b0;
    end
  end

  // Expiry setting the flag takes priority over a software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (expire) begin
      flag <= 1'b1;
    end else if (wr_intr && !w_data[FLAG_BIT]) begin
      flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      expr <= '0;
    end else if (wr_expr) begin
      expr <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
    end else if (wr_counter) begin
      counter <= w_data;
    end else if (expire) begin
      counter <= '0;
    end else if (start) begin
      counter <= counter + 32'd1;
    end
  end

endmodule
